// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the program counter, a writable branch-target LUT and a
// call/return stack, with a start/done run handshake around the RUN state.
module pc_sequencer #(
    parameter int unsigned D          = 10,
    parameter int unsigned LW         = 5,
    parameter int unsigned SD         = 4,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned HALT_ADDR  = 381
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    input  logic          branch_en,
    input  logic          rel_en,
    input  logic [7:0]    rel_off,
    input  logic          call_en,
    input  logic          ret_en,
    input  logic          halt,
    input  logic [LW-1:0] lut_idx,
    input  logic          lut_we,
    input  logic [LW-1:0] lut_waddr,
    input  logic [D-1:0]  lut_wdata,
    output logic [D-1:0]  prog_ctr,
    output logic          fetch_valid,
    output logic          busy,
    output logic          done,
    output logic          stack_err
);

    localparam int unsigned SPW = $clog2(SD + 1);
    localparam int unsigned SIW = (SD > 1) ? $clog2(SD) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [D-1:0]     pc_n;
    logic [SPW-1:0]   sp, sp_n;
    logic             err_n;
    logic             push;
    logic [D-1:0]     lut [2**LW];
    logic [D-1:0]     stack_mem [SD];
    logic [D-1:0]     pc_inc;
    logic [D-1:0]     rel_ext;
    logic [D-1:0]     lut_rd;
    logic [SIW-1:0]   push_idx;
    logic [SIW-1:0]   top_idx;

    assign pc_inc   = prog_ctr + D'(1);
    // Size cast of a signed operand sign-extends, so the add wraps both ways.
    assign rel_ext  = D'($signed(rel_off));
    assign lut_rd   = lut[lut_idx];
    assign push_idx = SIW'(sp);
    assign top_idx  = SIW'(sp - SPW'(1));

    assign busy        = (state == RUN);
    assign fetch_valid = (state == RUN);
    assign done        = (state == DONE);

    always_comb begin
        state_n = state;
        pc_n    = prog_ctr;
        sp_n    = sp;
        err_n   = stack_err;
        push    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = RUN;
                    pc_n    = D'(START_ADDR);
                    sp_n    = '0;
                    err_n   = 1'b0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (halt || prog_ctr == D'(HALT_ADDR)) begin
                        state_n = DONE;
                    end else if (ret_en) begin
                        if (sp == '0) begin
                            err_n   = 1'b1;
                            state_n = DONE;
                        end else begin
                            pc_n = stack_mem[top_idx];
                            sp_n = sp - SPW'(1);
                        end
                    end else if (call_en) begin
                        if (sp == SPW'(SD)) begin
                            err_n   = 1'b1;
                            state_n = DONE;
                        end else begin
                            push = 1'b1;
                            sp_n = sp + SPW'(1);
                            pc_n = lut_rd;
                        end
                    end else if (branch_en) begin
                        pc_n = lut_rd;
                    end else if (rel_en) begin
                        pc_n = prog_ctr + rel_ext;
                    end else begin
                        pc_n = pc_inc;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prog_ctr  <= '0;
            sp        <= '0;
            stack_err <= 1'b0;
        end else begin
            state     <= state_n;
            prog_ctr  <= pc_n;
            sp        <= sp_n;
            stack_err <= err_n;
        end
    end

    // Stack contents need no reset: the pointer alone defines what is live.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2**LW; i++) begin
                lut[i] <= '0;
            end
        end else if (lut_we) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic, all checked
// against a cycle-level reference model built from queues and plain integers.
module tb_pc_sequencer;

    localparam int D          = 10;
    localparam int LW         = 5;
    localparam int SD         = 4;
    localparam int START_ADDR = 0;
    localparam int HALT_ADDR  = 381;
    localparam int PC_MOD     = 1 << D;

    logic          clk = 1'b0;
    logic          reset, start, stall, branch_en, rel_en, call_en, ret_en, halt;
    logic [7:0]    rel_off;
    logic [LW-1:0] lut_idx, lut_waddr;
    logic          lut_we;
    logic [D-1:0]  lut_wdata;
    logic [D-1:0]  prog_ctr;
    logic          fetch_valid, busy, done, stack_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_running, m_done, m_err;
    int m_pc;
    int m_stack[$];
    int m_lut[2**LW];

    always #5 clk = ~clk;

    pc_sequencer #(
        .D(D), .LW(LW), .SD(SD), .START_ADDR(START_ADDR), .HALT_ADDR(HALT_ADDR)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_en(branch_en), .rel_en(rel_en), .rel_off(rel_off),
        .call_en(call_en), .ret_en(ret_en), .halt(halt), .lut_idx(lut_idx),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .prog_ctr(prog_ctr), .fetch_valid(fetch_valid), .busy(busy),
        .done(done), .stack_err(stack_err)
    );

    task automatic check_eq(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic clr_in();
        reset = 0; start = 0; stall = 0; branch_en = 0; rel_en = 0; rel_off = '0;
        call_en = 0; ret_en = 0; halt = 0; lut_idx = '0; lut_we = 0;
        lut_waddr = '0; lut_wdata = '0;
    endtask

    task automatic model_finish(input bit err);
        m_running = 0;
        m_done    = 1;
        if (err) m_err = 1;
    endtask

    // One clock of the architectural rules, applied to the inputs held at the edge.
    task automatic model_edge();
        if (reset) begin
            m_running = 0; m_done = 0; m_err = 0; m_pc = 0;
            m_stack.delete();
            foreach (m_lut[i]) m_lut[i] = 0;
            return;
        end
        if (!m_running) begin
            if (start) begin
                m_running = 1; m_done = 0; m_err = 0; m_pc = START_ADDR;
                m_stack.delete();
            end
        end else if (!stall) begin
            if (halt || m_pc == HALT_ADDR) model_finish(0);
            else if (ret_en) begin
                if (m_stack.size() == 0) model_finish(1);
                else m_pc = m_stack.pop_back();
            end else if (call_en) begin
                if (m_stack.size() == SD) model_finish(1);
                else begin
                    m_stack.push_back((m_pc + 1) % PC_MOD);
                    m_pc = m_lut[lut_idx];
                end
            end else if (branch_en) m_pc = m_lut[lut_idx];
            else if (rel_en) m_pc = ((m_pc + int'($signed(rel_off))) % PC_MOD + PC_MOD) % PC_MOD;
            else m_pc = (m_pc + 1) % PC_MOD;
        end
        if (lut_we) m_lut[lut_waddr] = lut_wdata;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("prog_ctr", int'(prog_ctr), m_pc);
        check_eq("busy", int'(busy), int'(m_running));
        check_eq("fetch_valid", int'(fetch_valid), int'(m_running));
        check_eq("done", int'(done), int'(m_done));
        check_eq("stack_err", int'(stack_err), int'(m_err));
        clr_in();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic lut_write(input int addr, input int data);
        lut_we = 1; lut_waddr = LW'(addr); lut_wdata = D'(data);
        step();
    endtask

    task automatic do_start();
        start = 1;
        step();
    endtask

    initial begin
        clr_in();
        @(negedge clk);

        // Reset state
        reset = 1; step();
        reset = 1; step();
        check_eq("reset_pc", int'(prog_ctr), 0);

        // Start, five plain increments, explicit halt
        do_start();
        check_eq("start_pc", int'(prog_ctr), START_ADDR);
        idle_steps(5);
        check_eq("pc_after_5", int'(prog_ctr), 5);
        halt = 1; step();
        check_eq("halt_done", int'(done), 1);
        check_eq("halt_pc", int'(prog_ctr), 5);
        idle_steps(2);

        // Call through LUT and return
        lut_write(3, 200);
        do_start();
        idle_steps(10);
        call_en = 1; lut_idx = 3; step();
        check_eq("call_pc", int'(prog_ctr), 200);
        ret_en = 1; step();
        check_eq("ret_pc", int'(prog_ctr), 11);

        // Stack overflow on the (SD+1)th nested call
        for (int i = 0; i < SD; i++) begin
            call_en = 1; lut_idx = 3; step();
        end
        call_en = 1; lut_idx = 3; step();
        check_eq("ovf_err", int'(stack_err), 1);
        check_eq("ovf_pc", int'(prog_ctr), 200);

        // Underflow after a fresh start
        do_start();
        check_eq("restart_err_clr", int'(stack_err), 0);
        ret_en = 1; step();
        check_eq("udf_err", int'(stack_err), 1);

        // Negative relative branch and PC wrap
        do_start();
        step();
        rel_en = 1; rel_off = 8'hFD; step();
        check_eq("rel_neg", int'(prog_ctr), 1022);
        step();
        step();
        check_eq("wrap_zero", int'(prog_ctr), 0);

        // Same-cycle LUT write returns the old value to the branch
        branch_en = 1; lut_idx = 3; lut_we = 1; lut_waddr = 3; lut_wdata = 10'd555;
        step();
        check_eq("lut_old", int'(prog_ctr), 200);
        branch_en = 1; lut_idx = 3; step();
        check_eq("lut_new", int'(prog_ctr), 555);

        // Stall freezes everything; on release call beats branch
        for (int i = 0; i < 3; i++) begin
            stall = 1; branch_en = 1; call_en = 1; lut_idx = 3; step();
        end
        check_eq("stall_pc", int'(prog_ctr), 555);
        branch_en = 1; call_en = 1; lut_idx = 3; step();
        ret_en = 1; step();
        check_eq("call_wins", int'(prog_ctr), 556);

        // Legacy halt address terminates the run
        lut_write(1, HALT_ADDR);
        branch_en = 1; lut_idx = 1; step();
        check_eq("at_halt_addr", int'(prog_ctr), HALT_ADDR);
        step();
        check_eq("halt_addr_done", int'(done), 1);

        // Mid-run reset
        do_start();
        idle_steps(3);
        reset = 1; step();
        check_eq("midrst_pc", int'(prog_ctr), 0);
        check_eq("midrst_done", int'(done), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            start     = ($urandom_range(0, 9) == 0);
            stall     = ($urandom_range(0, 7) == 0);
            halt      = ($urandom_range(0, 49) == 0);
            ret_en    = ($urandom_range(0, 5) == 0);
            call_en   = ($urandom_range(0, 5) == 0);
            branch_en = ($urandom_range(0, 5) == 0);
            rel_en    = ($urandom_range(0, 4) == 0);
            rel_off   = 8'($urandom);
            lut_idx   = LW'($urandom);
            lut_we    = ($urandom_range(0, 3) == 0);
            lut_waddr = LW'($urandom);
            lut_wdata = D'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
